// File: rtl/ethernet_package.sv
// Shared definitions for the ethernet receive path: slot states and frame-size constants.
package ethernet_package;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_RECEIVE = 2'd1,
    S_LOAD    = 2'd2,
    S_READ    = 2'd3
  } slot_state_e;

  localparam int unsigned FCS_BYTES       = 4;
  localparam int unsigned MIN_FRAME_BYTES = FCS_BYTES + 1;

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port; the read register holds its value when rd_en is low.
module simple_dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2048
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register doubles as the slot's output data register, so it is reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ethernet_receive_que_slot.sv
// One receive queue slot: buffers a parser frame, drops the FCS, commits or discards it,
// then replays the committed payload to the fabric over a valid/ready byte stream.
module ethernet_receive_que_slot
  import ethernet_package::*;
#(
  parameter int unsigned BUFFER_DEPTH     = 2048,
  parameter int unsigned DROP_COUNT_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [7:0]                      packet_data,
  input  logic                            packet_data_valid,
  input  logic                            good_packet,
  input  logic                            bad_packet,
  output logic                            slot_enable,
  output logic [7:0]                      read_data,
  output logic                            read_valid,
  output logic                            read_last,
  input  logic                            read_ready,
  output logic [$clog2(BUFFER_DEPTH):0]   packet_length,
  output logic [DROP_COUNT_WIDTH-1:0]     dropped_count
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW = AW + 1;

  slot_state_e             state_q, state_d;
  logic [CW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    overflow_q, overflow_d;
  logic [CW-1:0]           length_q, length_d;
  logic [DROP_COUNT_WIDTH-1:0] dropped_q, dropped_d;
  logic                    slot_enable_q, slot_enable_d;
  logic                    read_valid_q, read_valid_d;
  logic                    read_last_q, read_last_d;

  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic                    ram_re;
  logic [AW-1:0]           ram_raddr;
  logic [7:0]              ram_rdata;

  // The RAM read register is the output data register; it advances only on a handshake.
  simple_dual_port_ram #(
    .DATA_WIDTH (8),
    .DEPTH      (BUFFER_DEPTH)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (packet_data),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    length_d      = length_q;
    dropped_d     = dropped_q;
    slot_enable_d = slot_enable_q;
    read_valid_d  = read_valid_q;
    read_last_d   = read_last_q;
    ram_we        = 1'b0;
    ram_waddr     = wr_ptr_q[AW-1:0];
    ram_re        = 1'b0;
    ram_raddr     = rd_ptr_q[AW-1:0];

    case (state_q)
      S_EMPTY: begin
        if (packet_data_valid) begin
          ram_we        = 1'b1;
          wr_ptr_d      = CW'(1);
          slot_enable_d = 1'b0;
          state_d       = S_RECEIVE;
        end
      end

      S_RECEIVE: begin
        // A byte arriving alongside the verdict pulse belongs to nothing and is dropped.
        if (good_packet || bad_packet) begin
          if (bad_packet || overflow_q || (wr_ptr_q < CW'(MIN_FRAME_BYTES))) begin
            state_d       = S_EMPTY;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            overflow_d    = 1'b0;
            slot_enable_d = 1'b1;
            if (dropped_q != '1) dropped_d = dropped_q + DROP_COUNT_WIDTH'(1);
          end else begin
            length_d = wr_ptr_q - CW'(FCS_BYTES);
            rd_ptr_d = '0;
            state_d  = S_LOAD;
          end
        end else if (packet_data_valid) begin
          if (wr_ptr_q == CW'(BUFFER_DEPTH)) begin
            overflow_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + CW'(1);
          end
        end
      end

      S_LOAD: begin
        ram_re       = 1'b1;
        ram_raddr    = '0;
        rd_ptr_d     = CW'(1);
        read_valid_d = 1'b1;
        read_last_d  = (length_q == CW'(1));
        state_d      = S_READ;
      end

      S_READ: begin
        if (read_valid_q && read_ready) begin
          if (read_last_q) begin
            read_valid_d  = 1'b0;
            read_last_d   = 1'b0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            slot_enable_d = 1'b1;
            state_d       = S_EMPTY;
          end else begin
            ram_re      = 1'b1;
            rd_ptr_d    = rd_ptr_q + CW'(1);
            read_last_d = (rd_ptr_q == (length_q - CW'(1)));
          end
        end
      end

      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_EMPTY;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      length_q      <= '0;
      dropped_q     <= '0;
      slot_enable_q <= 1'b1;
      read_valid_q  <= 1'b0;
      read_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      length_q      <= length_d;
      dropped_q     <= dropped_d;
      slot_enable_q <= slot_enable_d;
      read_valid_q  <= read_valid_d;
      read_last_q   <= read_last_d;
    end
  end

  assign slot_enable   = slot_enable_q;
  assign read_data     = ram_rdata;
  assign read_valid    = read_valid_q;
  assign read_last     = read_last_q;
  assign packet_length = length_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_ethernet_receive_que_slot.sv
// Scoreboard bench for ethernet_receive_que_slot: payload bytes are queued at commit and popped on handshake.
module tb_ethernet_receive_que_slot;

  localparam int unsigned DEPTH = 2048;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  packet_data;
  logic        packet_data_valid;
  logic        good_packet;
  logic        bad_packet;
  logic        slot_enable;
  logic [7:0]  read_data;
  logic        read_valid;
  logic        read_last;
  logic        read_ready = 1'b0;
  logic [11:0] packet_length;
  logic [15:0] dropped_count;

  ethernet_receive_que_slot #(
    .BUFFER_DEPTH     (DEPTH),
    .DROP_COUNT_WIDTH (16)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .packet_data       (packet_data),
    .packet_data_valid (packet_data_valid),
    .good_packet       (good_packet),
    .bad_packet        (bad_packet),
    .slot_enable       (slot_enable),
    .read_data         (read_data),
    .read_valid        (read_valid),
    .read_last         (read_last),
    .read_ready        (read_ready),
    .packet_length     (packet_length),
    .dropped_count     (dropped_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned exp_len     = 0;
  int unsigned exp_drop    = 0;
  int          rdy_mode    = 0;
  logic        after_last  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expd);
    vectors++;
    if (act !== expd) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expd, $time);
    end
  endtask

  // Fabric ready: 0 = always high, 1 = pseudo-random, 2 = held low.
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       read_ready = 1'b1;
      1:       read_ready = 1'($urandom_range(0, 1));
      default: read_ready = 1'b0;
    endcase
  end

  // Every valid cycle must present the scoreboard head, stalled or not.
  always @(negedge clock) begin
    if (!reset_n) begin
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        chk("valid_after_last", 32'(read_valid), 32'd0);
        chk("slot_en_after_last", 32'(slot_enable), 32'd1);
      end
      if (read_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'(read_valid), 32'd0);
        end else begin
          chk("read_data", 32'(read_data), 32'(sb[0].data));
          chk("read_last", 32'(read_last), 32'(sb[0].last));
          chk("packet_length", 32'(packet_length), exp_len);
          if (read_ready) void'(sb.pop_front());
        end
      end
      after_last = read_valid && read_ready && read_last;
    end
  end

  // end_kind: 0 = good_packet, 1 = bad_packet, 2 = no verdict (frame left open)
  task automatic send_frame(input int unsigned n, input int unsigned start, input int end_kind);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
      packet_data       = 8'(start + i);
      packet_data_valid = 1'b1;
    end
    @(posedge clock); #1;
    packet_data_valid = 1'b0;
    if (end_kind == 2) return;
    if (end_kind == 1) bad_packet = 1'b1;
    else               good_packet = 1'b1;
    if (end_kind == 0 && n > 4 && n <= DEPTH) begin
      exp_len = n - 4;
      for (int unsigned j = 0; j < n - 4; j++) begin
        e.data = 8'(start + j);
        e.last = (j == n - 5);
        sb.push_back(e);
      end
    end else begin
      exp_drop++;
    end
    @(posedge clock); #1;
    good_packet = 1'b0;
    bad_packet  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !read_valid) return;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_slot_enable"}, 32'(slot_enable), 32'd1);
    chk({tag, "_read_valid"}, 32'(read_valid), 32'd0);
    chk({tag, "_read_last"}, 32'(read_last), 32'd0);
    chk({tag, "_read_data"}, 32'(read_data), 32'd0);
    chk({tag, "_packet_length"}, 32'(packet_length), 32'd0);
    chk({tag, "_dropped"}, 32'(dropped_count), 32'd0);
  endtask

  int unsigned hs;

  initial begin
    reset_n           = 1'b0;
    packet_data       = '0;
    packet_data_valid = 1'b0;
    good_packet       = 1'b0;
    bad_packet        = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // 64-byte frame committed; first byte two cycles after the good_packet cycle.
    send_frame(64, 0, 0);
    @(negedge clock);
    chk("lat_early_valid", 32'(read_valid), 32'd0);
    chk("slot_busy", 32'(slot_enable), 32'd0);
    @(negedge clock);
    chk("lat_first_valid", 32'(read_valid), 32'd1);
    wait_drain();
    chk("t1_dropped", 32'(dropped_count), exp_drop);

    // Same frame rejected by FCS.
    send_frame(64, 0, 1);
    @(negedge clock);
    chk("bad_slot_enable", 32'(slot_enable), 32'd1);
    chk("bad_read_valid", 32'(read_valid), 32'd0);
    chk("bad_dropped", 32'(dropped_count), exp_drop);

    // Oversized frame discarded despite good_packet.
    send_frame(DEPTH + 10, 8'h80, 0);
    repeat (4) @(negedge clock);
    chk("ovf_dropped", 32'(dropped_count), exp_drop);
    chk("ovf_slot_enable", 32'(slot_enable), 32'd1);

    // 4-byte runt discarded; 5-byte frame yields one payload byte.
    send_frame(4, 8'hA0, 0);
    repeat (2) @(negedge clock);
    chk("runt_dropped", 32'(dropped_count), exp_drop);
    send_frame(5, 8'h55, 0);
    wait_drain();

    // 100-byte frame with a stalling fabric.
    rdy_mode = 1;
    send_frame(100, 8'h10, 0);
    wait_drain();
    rdy_mode = 0;

    // 100-byte frame with ready held high must stream back-to-back.
    send_frame(100, 8'h20, 0);
    hs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (read_valid && read_ready) hs++;
      else if (hs > 0) break;
    end
    chk("burst_len", hs, 32'd96);
    wait_drain();
    chk("pre_reset_dropped", 32'(dropped_count), exp_drop);

    // Reset while a committed frame is being replayed.
    rdy_mode = 2;
    send_frame(64, 8'h40, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (read_valid) break;
    end
    chk("valid_before_reset", 32'(read_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midread_read_valid", 32'(read_valid), 32'd0);
    chk("midread_slot_enable", 32'(slot_enable), 32'd1);
    sb.delete();
    exp_drop = 0;
    rdy_mode = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Reset at byte 30 of an incoming frame, then a fresh frame.
    send_frame(30, 8'hC0, 2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midframe");
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    send_frame(64, 8'h00, 0);
    wait_drain();
    chk("final_dropped", 32'(dropped_count), 32'd0);
    chk("final_slot_enable", 32'(slot_enable), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
